// File: rtl/half_adder.sv
// Registered bitwise half adder with an optional input synchroniser chain.
// Each lane is independent: {Co[i],S[i]} = A[i] + B[i], latency SYNC_STAGES+1 edges.
module half_adder #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Co
);

  logic [WIDTH-1:0] a_sync;
  logic [WIDTH-1:0] b_sync;

  // Per-lane sum and carry packed as {carry, sum}.
  function automatic logic [2*WIDTH-1:0] half_add(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    return {x & y, x ^ y};
  endfunction

  // Stage p0..pN: synchroniser chain; bypassed entirely when SYNC_STAGES is 0.
  if (SYNC_STAGES == 0) begin : g_direct
    assign a_sync = A;
    assign b_sync = B;
  end else begin : g_sync
    logic [WIDTH-1:0] a_p [SYNC_STAGES];
    logic [WIDTH-1:0] b_p [SYNC_STAGES];

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
          a_p[i] <= '0;
          b_p[i] <= '0;
        end
      end else begin
        a_p[0] <= A;
        b_p[0] <= B;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          a_p[i] <= a_p[i-1];
          b_p[i] <= b_p[i-1];
        end
      end
    end

    assign a_sync = a_p[SYNC_STAGES-1];
    assign b_sync = b_p[SYNC_STAGES-1];
  end

  // Output stage: S/Co come only from flops so they never glitch.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      S  <= '0;
      Co <= '0;
    end else begin
      {Co, S} <= half_add(a_sync, b_sync);
    end
  end

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: a 1-lane, 2-stage-sync instance and a 4-lane, unsynchronised one.
module tb_half_adder;

  localparam int LAT_SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b1, b = 1'b1;
  logic       s, co;
  logic [3:0] wa = 4'hF, wb = 4'hF;
  logic [3:0] ws, wco;

  int vectors     = 0;
  int miscompares = 0;

  logic [1:0] sb  [$];
  logic [7:0] wsb [$];

  always #10 clk = ~clk;

  half_adder #(.WIDTH(1), .SYNC_STAGES(2)) dut (
    .CLOCK_50(clk), .RESET(rst), .A(a), .B(b), .S(s), .Co(co)
  );

  half_adder #(.WIDTH(4), .SYNC_STAGES(0)) dut_w (
    .CLOCK_50(clk), .RESET(rst), .A(wa), .B(wb), .S(ws), .Co(wco)
  );

  // After reset the narrow pipe emits LAT_SYNC zero results before the first real one.
  task automatic sb_flush();
    sb.delete();
    wsb.delete();
    for (int i = 0; i < LAT_SYNC; i++) sb.push_back(2'b00);
  endtask

  task automatic drive(input logic ai, input logic bi);
    a = ai;
    b = bi;
    sb.push_back({1'b0, ai} + {1'b0, bi});
  endtask

  task automatic test_reset();
    logic [1:0] exp;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({co, s} !== 2'b00 || {wco, ws} !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_hold cyc%0d: got co,s=%b%b wco,ws=%h, want 00 / 00", i, co, s, {wco, ws});
      end
    end
    #4 rst = 1'b0;
    sb_flush();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1);
      @(posedge clk); #1;
      exp = (sb.size() != 0) ? sb.pop_front() : 2'bxx;
      vectors++;
      if ({co, s} !== exp) begin
        miscompares++;
        $display("FAIL reset_release edge%0d: got co,s=%b%b want %b", i + 1, co, s, exp);
      end
    end
  endtask

  task automatic test_truth_table();
    logic [1:0] exp;
    logic [1:0] tab [4];
    tab = '{2'b00, 2'b01, 2'b01, 2'b10};
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 5; c++) begin
        drive(p[1], p[0]);
        @(posedge clk); #1;
        exp = (sb.size() != 0) ? sb.pop_front() : 2'bxx;
        vectors++;
        if ({co, s} !== exp) begin
          miscompares++;
          $display("FAIL truth ab=%0d%0d cyc%0d: got co,s=%b%b want %b", p[1], p[0], c, co, s, exp);
        end
      end
      vectors++;
      if ({co, s} !== tab[p]) begin
        miscompares++;
        $display("FAIL truth_end ab=%0d%0d: got co,s=%b%b want %b", p[1], p[0], co, s, tab[p]);
      end
    end
  endtask

  task automatic test_latency();
    logic [1:0] exp;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0);
      @(posedge clk); #1;
      exp = (sb.size() != 0) ? sb.pop_front() : 2'bxx;
      vectors++;
      if ({co, s} !== exp) begin
        miscompares++;
        $display("FAIL latency_settle cyc%0d: got co,s=%b%b want %b", c, co, s, exp);
      end
    end
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b0);
      @(posedge clk); #1;
      exp = (sb.size() != 0) ? sb.pop_front() : 2'bxx;
      vectors++;
      if ({co, s} !== exp || s !== (k >= 3)) begin
        miscompares++;
        $display("FAIL latency edge%0d: got co,s=%b%b want %b (s=%0d)", k, co, s, exp, k >= 3);
      end
    end
  endtask

  task automatic test_streaming();
    logic [1:0] exp;
    logic [1:0] seq [7];
    seq = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    for (int c = 0; c < 7; c++) begin
      drive(seq[c][1], seq[c][0]);
      @(posedge clk); #1;
      exp = (sb.size() != 0) ? sb.pop_front() : 2'bxx;
      vectors++;
      if ({co, s} !== exp) begin
        miscompares++;
        $display("FAIL stream cyc%0d: got co,s=%b%b want %b", c, co, s, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] exp;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive(1'b1, 1'b0);
      else       drive(1'b1, 1'b1);
      @(posedge clk); #1;
      exp = (sb.size() != 0) ? sb.pop_front() : 2'bxx;
      vectors++;
      if ({co, s} !== exp) begin
        miscompares++;
        $display("FAIL async_pre cyc%0d: got co,s=%b%b want %b", c, co, s, exp);
      end
    end
    #8;
    vectors++;
    if ({co, s} !== 2'b01) begin
      miscompares++;
      $display("FAIL async_before_pulse: got co,s=%b%b want 01", co, s);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({co, s} !== 2'b00 || {wco, ws} !== 8'h00) begin
      miscompares++;
      $display("FAIL async_clear: got co,s=%b%b wco,ws=%h want 00 / 00", co, s, {wco, ws});
    end
    #2 rst = 1'b0;
    sb_flush();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b1);
      @(posedge clk); #1;
      exp = (sb.size() != 0) ? sb.pop_front() : 2'bxx;
      vectors++;
      if ({co, s} !== exp) begin
        miscompares++;
        $display("FAIL async_resume edge%0d: got co,s=%b%b want %b", k, co, s, exp);
      end
    end
  endtask

  task automatic test_wide();
    logic [7:0] exp;
    logic [1:0] lane;
    logic [3:0] es, ec;
    for (int v = 0; v < 8; v++) begin
      if (v == 0) begin
        wa = 4'b1100;
        wb = 4'b1010;
      end else begin
        wa = 4'($urandom_range(0, 15));
        wb = 4'($urandom_range(0, 15));
      end
      for (int j = 0; j < 4; j++) begin
        lane  = {1'b0, wa[j]} + {1'b0, wb[j]};
        es[j] = lane[0];
        ec[j] = lane[1];
      end
      wsb.push_back({ec, es});
      @(posedge clk); #1;
      exp = (wsb.size() != 0) ? wsb.pop_front() : 8'hxx;
      vectors++;
      if ({wco, ws} !== exp) begin
        miscompares++;
        $display("FAIL wide a=%b b=%b: got co=%b s=%b want co=%b s=%b", wa, wb, wco, ws, exp[7:4], exp[3:0]);
      end
      if (v == 0) begin
        vectors++;
        if (ws !== 4'b0110 || wco !== 4'b1000) begin
          miscompares++;
          $display("FAIL wide_fixed: got co=%b s=%b want co=1000 s=0110", wco, ws);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_latency();
    test_streaming();
    test_async_reset();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
